access_code_rx: RTL

- Receive-side access-code correlator for the BR baseband.
- Slides the demodulated rxbit stream through a 64-bit window and counts Hamming errors against the selected sync word.
- Declares sync when the error count is at or below a register threshold.
- Emits rx_trailer_st_p, which re-aligns the header bit processor for header/HEC decode, or id_rcvd_p for ID packets, which carry no trailer.

---
 rtl/access_code_rx_pkg.sv | 14 +
 rtl/access_code_rx_if.sv | 28 ++
 rtl/access_code_rx_popcount64.sv | 31 +++
 rtl/access_code_rx.sv | 88 ++++++++
 4 files changed

// File: rtl/access_code_rx_pkg.sv
// Shared baseband constants for the access-code receive correlator.
package access_code_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    TRAILER = 2'd2,
    DONE    = 2'd3
  } acrx_state_t;

  localparam int         SYNC_LEN     = 64;
  localparam logic [6:0] DEF_CORR_THR = 7'd7;

endpackage

// File: rtl/access_code_rx_if.sv
// Bit-stream / sync-event bundle between slot timing, demod and the correlator.
interface access_code_rx_if;
  import access_code_rx_pkg::*;

  logic                p_1us;
  logic                rxbit;
  logic                search_en;
  logic                id_mode;
  logic [SYNC_LEN-1:0] syncword;
  logic [6:0]          regi_corr_thr;
  logic                sync_found_p;
  logic                rx_trailer_st_p;
  logic                id_rcvd_p;
  logic                sync_miss_p;
  logic [6:0]          corr_errs;
  logic                rx_busy;

  modport master (
    output p_1us, rxbit, search_en, id_mode, syncword, regi_corr_thr,
    input  sync_found_p, rx_trailer_st_p, id_rcvd_p, sync_miss_p, corr_errs, rx_busy
  );

  modport slave (
    input  p_1us, rxbit, search_en, id_mode, syncword, regi_corr_thr,
    output sync_found_p, rx_trailer_st_p, id_rcvd_p, sync_miss_p, corr_errs, rx_busy
  );

endinterface

// File: rtl/access_code_rx_popcount64.sv
// Combinational 64-bit population count as a balanced adder tree.
module popcount64 (
  input  logic [63:0] din,
  output logic [6:0]  cnt
);

  logic [31:0][1:0] l1;
  logic [15:0][2:0] l2;
  logic [7:0][3:0]  l3;
  logic [3:0][4:0]  l4;
  logic [1:0][5:0]  l5;

  for (genvar g = 0; g < 32; g++) begin : g_l1
    assign l1[g] = {1'b0, din[2*g]} + {1'b0, din[2*g+1]};
  end
  for (genvar g = 0; g < 16; g++) begin : g_l2
    assign l2[g] = {1'b0, l1[2*g]} + {1'b0, l1[2*g+1]};
  end
  for (genvar g = 0; g < 8; g++) begin : g_l3
    assign l3[g] = {1'b0, l2[2*g]} + {1'b0, l2[2*g+1]};
  end
  for (genvar g = 0; g < 4; g++) begin : g_l4
    assign l4[g] = {1'b0, l3[2*g]} + {1'b0, l3[2*g+1]};
  end
  for (genvar g = 0; g < 2; g++) begin : g_l5
    assign l5[g] = {1'b0, l4[2*g]} + {1'b0, l4[2*g+1]};
  end

  assign cnt = {1'b0, l5[0]} + {1'b0, l5[1]};

endmodule

// File: rtl/access_code_rx.sv
// Access-code correlator: sliding 64-bit window vs sync word, Hamming threshold,
// then trailer-start or ID-received strobe on the 1 us bit grid.
module access_code_rx
  import access_code_rx_pkg::*;
#(
  parameter int TRL_DLY  = 2,
  parameter int FILL_MIN = 64
) (
  input  logic            clk_6M,
  input  logic            rstz,
  access_code_rx_if.slave bus
);

  acrx_state_t         state, state_nxt;
  logic [SYNC_LEN-1:0] sreg, sreg_shf;
  logic [6:0]          fill, fill_inc, errs, corr_errs_q;
  logic [2:0]          tcnt;
  logic                hit;

  // Correlation is judged on the window as it will look after this strobe's shift.
  assign sreg_shf = {sreg[SYNC_LEN-2:0], bus.rxbit};

  popcount64 u_popcnt (
    .din (sreg_shf ^ bus.syncword),
    .cnt (errs)
  );

  assign fill_inc = (fill >= 7'(FILL_MIN)) ? fill : fill + 7'd1;
  assign hit      = bus.p_1us && (state == SEARCH) &&
                    (fill_inc >= 7'(FILL_MIN)) && (errs <= bus.regi_corr_thr);

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.search_en) state_nxt = SEARCH;
      SEARCH:  if (hit)                 state_nxt = bus.id_mode ? DONE : TRAILER;
               else if (!bus.search_en) state_nxt = IDLE;
      // Packet is committed once sync is seen; search_en no longer matters here.
      TRAILER: if (bus.p_1us && tcnt == 3'd0) state_nxt = DONE;
      DONE:    if (!bus.search_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.sync_found_p    = 1'b0;
    bus.id_rcvd_p       = 1'b0;
    bus.sync_miss_p     = 1'b0;
    bus.rx_trailer_st_p = 1'b0;
    case (state)
      SEARCH: begin
        bus.sync_found_p = hit;
        bus.id_rcvd_p    = hit && bus.id_mode;
        bus.sync_miss_p  = !hit && !bus.search_en;
      end
      TRAILER: bus.rx_trailer_st_p = bus.p_1us && (tcnt == 3'd0);
      default: ;
    endcase
  end

  assign bus.rx_busy   = (state != IDLE);
  assign bus.corr_errs = corr_errs_q;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      sreg        <= '0;
      fill        <= '0;
      tcnt        <= '0;
      corr_errs_q <= '0;
    end else begin
      if (bus.p_1us && state != IDLE) sreg <= sreg_shf;
      if (state == IDLE)                     fill <= '0;
      else if (state == SEARCH && bus.p_1us) fill <= fill_inc;
      if (hit) begin
        corr_errs_q <= errs;
        tcnt        <= 3'(TRL_DLY - 1);
      end else if (state == TRAILER && bus.p_1us && tcnt != 3'd0) begin
        tcnt <= tcnt - 3'd1;
      end
    end
  end

endmodule
